// File: rtl/ahb_slave_arbiter.sv
// Round-robin arbiter granting one AHB master channel access to a shared slave; holds the grant through fixed-length bursts.
// Optional macro AHB_ARB_LOCK_EN adds hmastlock, which blocks re-arbitration in OWN.
module ahb_slave_arbiter #(
  parameter int CHANNEL_NUM = 1,
  parameter int MI_W        = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [CHANNEL_NUM-1:0] hreq,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
`ifdef AHB_ARB_LOCK_EN
  input  logic                   hmastlock,
`endif
  output logic [CHANNEL_NUM-1:0] hgrant,
  output logic [MI_W-1:0]        hmaster,
  output logic                   arb_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_BURST} state_t;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  state_t                 state, state_nxt;
  logic [CHANNEL_NUM-1:0] grant_nxt;
  logic [MI_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic [3:0]             beat_cnt, beat_cnt_nxt;
  logic [MI_W-1:0]        cur_idx, nxt_ptr, idle_idx, rearb_idx;
  logic                   lock_hold, release_cond, do_rearb;

  function automatic logic [MI_W-1:0] onehot_idx(input logic [CHANNEL_NUM-1:0] v);
    logic [MI_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < CHANNEL_NUM; i++)
      if (v[i]) idx = MI_W'(i);
    return idx;
  endfunction

  // Rotate the request vector so the search starts at 'start', then map back.
  function automatic logic [MI_W-1:0] rr_pick(input logic [CHANNEL_NUM-1:0] req,
                                              input logic [MI_W-1:0] start);
    logic [2*CHANNEL_NUM-1:0] dbl;
    logic [CHANNEL_NUM-1:0]   rot;
    int                       pos;
    dbl = {req, req} >> start;
    rot = dbl[CHANNEL_NUM-1:0];
    pos = 0;
    for (int i = CHANNEL_NUM-1; i >= 0; i--)
      if (rot[i]) pos = i;
    pos = pos + int'(start);
    if (pos >= CHANNEL_NUM) pos = pos - CHANNEL_NUM;
    return MI_W'(pos);
  endfunction

  function automatic logic [3:0] burst_last(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4'd3;
      3'd4, 3'd5: return 4'd7;
      3'd6, 3'd7: return 4'd15;
      default:    return 4'd0;
    endcase
  endfunction

`ifdef AHB_ARB_LOCK_EN
  assign lock_hold = hmastlock;
`else
  assign lock_hold = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      hgrant   <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hgrant   <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = hgrant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    do_rearb     = 1'b0;
    cur_idx      = onehot_idx(hgrant);
    nxt_ptr      = (cur_idx == MI_W'(CHANNEL_NUM-1)) ? '0 : cur_idx + 1'b1;
    idle_idx     = rr_pick(hreq, rr_ptr);
    rearb_idx    = rr_pick(hreq, nxt_ptr);
    release_cond = !lock_hold && ((htrans == TR_IDLE) || !hreq[cur_idx]);
    case (state)
      ST_IDLE: begin
        if (|hreq) begin
          grant_nxt = CHANNEL_NUM'(1) << idle_idx;
          state_nxt = ST_OWN;
        end
      end
      ST_OWN: begin
        if (hready) begin
          if (release_cond) begin
            do_rearb = 1'b1;
          end else if (htrans == TR_NONSEQ && hburst[2:1] != 2'b00) begin
            beat_cnt_nxt = burst_last(hburst);
            state_nxt    = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (hready) begin
          if (htrans == TR_SEQ) begin
            if (beat_cnt <= 4'd1) begin
              beat_cnt_nxt = 4'd0;
              state_nxt    = ST_OWN;
            end else begin
              beat_cnt_nxt = beat_cnt - 4'd1;
            end
          end else if (htrans == TR_IDLE) begin
            // Early termination hands over on this same edge unless locked.
            beat_cnt_nxt = 4'd0;
            state_nxt    = ST_OWN;
            do_rearb     = !lock_hold;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
    if (do_rearb) begin
      rr_ptr_nxt = nxt_ptr;
      if (|hreq) begin
        grant_nxt = CHANNEL_NUM'(1) << rearb_idx;
        state_nxt = ST_OWN;
      end else begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
    end
  end

  always_comb begin
    hmaster  = onehot_idx(hgrant);
    arb_busy = |hgrant;
  end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Testbench for ahb_slave_arbiter with four channels: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_ahb_slave_arbiter;
  localparam int NCH = 4;

  logic           HCLK = 1'b0;
  logic           HRESETn;
  logic [NCH-1:0] hreq;
  logic [1:0]     htrans;
  logic [2:0]     hburst;
  logic           hready;
  logic           hmastlock;
  logic [NCH-1:0] hgrant;
  logic [1:0]     hmaster;
  logic           arb_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: current owner (-1 none), remaining SEQ beats of a fixed burst, search start
  int m_owner, m_left, m_ptr;

  ahb_slave_arbiter #(.CHANNEL_NUM(NCH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hreq(hreq), .htrans(htrans), .hburst(hburst),
    .hready(hready),
`ifdef AHB_ARB_LOCK_EN
    .hmastlock(hmastlock),
`endif
    .hgrant(hgrant), .hmaster(hmaster), .arb_busy(arb_busy)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [1:0] t, input logic [2:0] b, input logic rdy);
    hreq = r; htrans = t; hburst = b; hready = rdy;
  endtask

  function automatic int m_pick(input logic [3:0] req, input int from);
    int c;
    for (int k = 0; k < NCH; k++) begin
      c = (from + k) % NCH;
      if (req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  function automatic void m_handover(input logic [3:0] req);
    m_ptr   = (m_owner + 1) % NCH;
    m_owner = m_pick(req, m_ptr);
  endfunction

  function automatic void m_edge(input logic [3:0] req, input logic [1:0] tr,
                                 input logic [2:0] bu, input logic rdy, input logic lk);
    int b;
    b = int'(bu);
    if (m_owner < 0) begin
      m_owner = m_pick(req, m_ptr);
    end else if (rdy) begin
      if (m_left > 0) begin
        if (tr == 2'd3) m_left = m_left - 1;
        else if (tr == 2'd0) begin
          m_left = 0;
          if (!lk) m_handover(req);
        end
      end else if (!lk && (tr == 2'd0 || !req[m_owner[1:0]])) begin
        m_handover(req);
      end else if (tr == 2'd2 && b >= 2) begin
        m_left = ((b < 4) ? 4 : (b < 6) ? 8 : 16) - 1;
      end
    end
  endfunction

  task automatic test_reset();
    HRESETn = 1'b0; hmastlock = 1'b0;
    drive(4'b0000, 2'd0, 3'd0, 1'b1);
    tick(); tick();
    n_cmp++;
    if (hgrant !== 4'b0000 || hmaster !== 2'd0 || arb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: hgrant=%b hmaster=%0d busy=%b, want 0000/0/0", hgrant, hmaster, arb_busy);
    end
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (hgrant !== 4'b0000 || arb_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_req[%0d]: hgrant=%b busy=%b, want 0000/0", i, hgrant, arb_busy);
      end
    end
  endtask

  task automatic test_first_grant();
    drive(4'b0101, 2'd2, 3'd0, 1'b1);
    tick();
    n_cmp++;
    if (hgrant !== 4'b0001 || hmaster !== 2'd0 || arb_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: hgrant=%b hmaster=%0d busy=%b, want 0001/0/1", hgrant, hmaster, arb_busy);
    end
    drive(4'b0100, 2'd0, 3'd0, 1'b0);
    tick();
    n_cmp++;
    if (hgrant !== 4'b0001 || hmaster !== 2'd0) begin
      n_fail++;
      $display("FAIL release_stalled: hgrant=%b hmaster=%0d, want 0001/0", hgrant, hmaster);
    end
    hready = 1'b1;
    tick();
    n_cmp++;
    if (hgrant !== 4'b0100 || hmaster !== 2'd2) begin
      n_fail++;
      $display("FAIL release_to_ch2: hgrant=%b hmaster=%0d, want 0100/2", hgrant, hmaster);
    end
  endtask

  task automatic test_incr4_burst();
    logic [1:0] tr_seq [5] = '{2'd3, 2'd3, 2'd1, 2'd3, 2'd3};
    logic       rd_seq [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    drive(4'b0101, 2'd2, 3'd3, 1'b1);
    tick();
    n_cmp++;
    if (hgrant !== 4'b0100) begin
      n_fail++;
      $display("FAIL incr4_start: hgrant=%b, want 0100", hgrant);
    end
    // owner drops its request during the burst; ch0 keeps requesting
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, tr_seq[i], 3'd3, rd_seq[i]);
      tick();
      n_cmp++;
      if (hgrant !== 4'b0100 || hmaster !== 2'd2) begin
        n_fail++;
        $display("FAIL incr4_hold[%0d]: hgrant=%b hmaster=%0d, want 0100/2", i, hgrant, hmaster);
      end
    end
    drive(4'b0001, 2'd2, 3'd0, 1'b1);
    tick();
    n_cmp++;
    if (hgrant !== 4'b0001 || hmaster !== 2'd0) begin
      n_fail++;
      $display("FAIL incr4_after: hgrant=%b hmaster=%0d, want 0001/0", hgrant, hmaster);
    end
  endtask

  task automatic test_wrap8_early();
    drive(4'b0011, 2'd2, 3'd4, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(4'b0011, 2'd3, 3'd4, 1'b1);
      tick();
      n_cmp++;
      if (hgrant !== 4'b0001) begin
        n_fail++;
        $display("FAIL wrap8_hold[%0d]: hgrant=%b, want 0001", i, hgrant);
      end
    end
    drive(4'b0011, 2'd0, 3'd4, 1'b1);
    tick();
    n_cmp++;
    if (hgrant !== 4'b0010 || hmaster !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap8_early_term: hgrant=%b hmaster=%0d, want 0010/1", hgrant, hmaster);
    end
    drive(4'b0001, 2'd2, 3'd0, 1'b1);
    tick();
    n_cmp++;
    if (hgrant !== 4'b0001 || hmaster !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap8_back_in_own: hgrant=%b hmaster=%0d, want 0001/0", hgrant, hmaster);
    end
  endtask

  task automatic test_reset_mid_burst();
    drive(4'b0001, 2'd2, 3'd7, 1'b1);
    tick();
    drive(4'b0001, 2'd3, 3'd7, 1'b1);
    tick();
    #3;
    HRESETn = 1'b0;
    #1;
    n_cmp++;
    if (hgrant !== 4'b0000 || hmaster !== 2'd0 || arb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: hgrant=%b hmaster=%0d busy=%b, want 0000/0/0", hgrant, hmaster, arb_busy);
    end
    drive(4'b1000, 2'd0, 3'd0, 1'b1);
    tick(); tick();
    HRESETn = 1'b1;
    tick();
    n_cmp++;
    if (hgrant !== 4'b1000 || hmaster !== 2'd3) begin
      n_fail++;
      $display("FAIL post_reset_grant: hgrant=%b hmaster=%0d, want 1000/3", hgrant, hmaster);
    end
  endtask

`ifdef AHB_ARB_LOCK_EN
  task automatic test_lock();
    hmastlock = 1'b1;
    drive(4'b0001, 2'd0, 3'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (hgrant !== 4'b1000) begin
        n_fail++;
        $display("FAIL lock_hold[%0d]: hgrant=%b, want 1000", i, hgrant);
      end
    end
    hmastlock = 1'b0;
    tick();
    n_cmp++;
    if (hgrant !== 4'b0001 || hmaster !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_release: hgrant=%b hmaster=%0d, want 0001/0", hgrant, hmaster);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] exp_g;
    logic [1:0] exp_m;
    logic       lk;
    HRESETn = 1'b0; hmastlock = 1'b0;
    drive(4'b0000, 2'd0, 3'd0, 1'b1);
    tick(); tick();
    HRESETn = 1'b1;
    m_owner = -1; m_left = 0; m_ptr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      lk = 1'b0;
`ifdef AHB_ARB_LOCK_EN
      lk = ($urandom_range(0, 3) == 0);
      hmastlock = lk;
`endif
      m_edge(hreq, htrans, hburst, hready, lk);
      tick();
      exp_g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      exp_m = (m_owner < 0) ? 2'd0 : m_owner[1:0];
      n_cmp++;
      if (hgrant !== exp_g || hmaster !== exp_m || arb_busy !== (m_owner >= 0)) begin
        n_fail++;
        $display("FAIL random[%0d]: hgrant=%b hmaster=%0d busy=%b, want %b/%0d/%b",
                 cyc, hgrant, hmaster, arb_busy, exp_g, exp_m, (m_owner >= 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_incr4_burst();
    test_wrap8_early();
    test_reset_mid_burst();
`ifdef AHB_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
